// File: rtl/gshare_branch_predictor.sv
// gshare / bimodal branch direction predictor.
// 2-bit counter table, registered lookup, non-speculative history.
module gshare_branch_predictor #(
  parameter int         INDEX_BITS = 6,
  parameter int         HIST_BITS  = 4,
  parameter int         PC_LSB     = 2,
  parameter logic [1:0] INIT_STATE = 2'b01,
  parameter int         STAT_BITS  = 16,
  localparam int        GW = (HIST_BITS > 0) ? HIST_BITS : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lookup_valid,
  input  logic [31:0]           lookup_pc,
  output logic                  pred_valid,
  output logic                  pred_taken,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_taken,
  input  logic                  upd_mispredict,
  output logic [GW-1:0]         ghr,
  output logic [STAT_BITS-1:0]  lookup_count,
  output logic [STAT_BITS-1:0]  mispredict_count
);

  localparam int N = 1 << INDEX_BITS;

  logic [1:0]            ctr_q [N];
  logic [INDEX_BITS-1:0] hist_idx;
  logic [INDEX_BITS-1:0] lk_idx;
  logic [1:0]            upd_cur;
  logic [1:0]            upd_next;
  logic                  pc_unused;

  assign pc_unused = ^lookup_pc;

  if (HIST_BITS == 0) begin : g_bimodal
    assign hist_idx = '0;
    assign ghr      = '0;
  end else begin : g_gshare
    // zero-extend history up to the index width
    always_comb begin
      hist_idx         = '0;
      hist_idx[GW-1:0] = ghr;
    end

    // history shifts in resolved outcomes only
    always_ff @(posedge clk) begin
      if (reset) begin
        ghr <= '0;
      end else if (upd_valid) begin
        if (HIST_BITS == 1) ghr <= upd_taken;
        else ghr <= {ghr[GW-2:0], upd_taken};
      end
    end
  end

  assign lk_idx  = lookup_pc[PC_LSB +: INDEX_BITS] ^ hist_idx;
  assign upd_cur = ctr_q[upd_index];

  // saturating step of the counter being updated
  always_comb begin
    upd_next = upd_cur;
    unique case (1'b1)
      upd_taken && (upd_cur != 2'b11):
        upd_next = upd_cur + 2'd1;
      !upd_taken && (upd_cur != 2'b00):
        upd_next = upd_cur - 2'd1;
      default: ;
    endcase
  end

  // counter table: whole-table reset, one write port
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) ctr_q[i] <= INIT_STATE;
    end else if (upd_valid) begin
      ctr_q[upd_index] <= upd_next;
    end
  end

  // registered prediction reads pre-update contents
  always_ff @(posedge clk) begin
    if (reset) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_index <= '0;
    end else begin
      pred_valid <= lookup_valid;
      if (lookup_valid) begin
        pred_taken <= ctr_q[lk_idx][1];
        pred_index <= lk_idx;
      end
    end
  end

  // saturating statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      lookup_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (lookup_valid && (lookup_count != '1))
        lookup_count <= lookup_count + STAT_BITS'(1);
      if (upd_valid && upd_mispredict &&
          (mispredict_count != '1))
        mispredict_count <= mispredict_count + STAT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Bench for gshare_branch_predictor: a bimodal and a gshare
// instance share stimulus; a reference model feeds a scoreboard.
module tb_gshare_branch_predictor;

  typedef struct packed {
    logic       v;
    logic       t;
    logic [3:0] i;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        upd_valid;
  logic [3:0]  upd_index;
  logic        upd_taken;
  logic        upd_mispredict;

  logic        bi_pv, bi_pt;
  logic [3:0]  bi_pi;
  logic [0:0]  bi_ghr;
  logic [15:0] bi_lk, bi_mp;

  logic        gs_pv, gs_pt;
  logic [3:0]  gs_pi;
  logic [3:0]  gs_ghr;
  logic [3:0]  gs_lk, gs_mp;

  int vectors = 0;
  int errors  = 0;

  logic [1:0] m_ctr [2][16];
  logic [3:0] m_ghr [2];
  logic       m_pt  [2];
  logic [3:0] m_pi  [2];
  int         m_lk  [2];
  int         m_mp  [2];
  int         m_max [2] = '{65535, 15};
  exp_t       sbq [$];

  always #5 clk = ~clk;

  gshare_branch_predictor #(
    .INDEX_BITS(4), .HIST_BITS(0), .STAT_BITS(16)
  ) u_bi (
    .clk(clk), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(bi_pv), .pred_taken(bi_pt),
    .pred_index(bi_pi),
    .upd_valid(upd_valid), .upd_index(upd_index),
    .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict),
    .ghr(bi_ghr),
    .lookup_count(bi_lk), .mispredict_count(bi_mp)
  );

  gshare_branch_predictor #(
    .INDEX_BITS(4), .HIST_BITS(4), .STAT_BITS(4)
  ) u_gs (
    .clk(clk), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(gs_pv), .pred_taken(gs_pt),
    .pred_index(gs_pi),
    .upd_valid(upd_valid), .upd_index(upd_index),
    .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict),
    .ghr(gs_ghr),
    .lookup_count(gs_lk), .mispredict_count(gs_mp)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic lv,
                       input logic [31:0] pc,
                       input logic uv, input logic [3:0] ui,
                       input logic ut, input logic um);
    exp_t       e;
    logic [3:0] idx;
    reset          = r;
    lookup_valid   = lv;
    lookup_pc      = pc;
    upd_valid      = uv;
    upd_index      = ui;
    upd_taken      = ut;
    upd_mispredict = um;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        e = '0;
        for (int j = 0; j < 16; j++) m_ctr[k][j] = 2'b01;
        m_ghr[k] = '0;
        m_pt[k]  = 1'b0;
        m_pi[k]  = '0;
        m_lk[k]  = 0;
        m_mp[k]  = 0;
      end else begin
        if (lv) begin
          idx     = pc[5:2] ^ m_ghr[k];
          e.v     = 1'b1;
          e.t     = m_ctr[k][idx][1];
          e.i     = idx;
          m_pt[k] = e.t;
          m_pi[k] = idx;
          if (m_lk[k] < m_max[k]) m_lk[k]++;
        end else begin
          e.v = 1'b0;
          e.t = m_pt[k];
          e.i = m_pi[k];
        end
        if (uv) begin
          if (ut && m_ctr[k][ui] != 2'b11)
            m_ctr[k][ui] = m_ctr[k][ui] + 2'd1;
          if (!ut && m_ctr[k][ui] != 2'b00)
            m_ctr[k][ui] = m_ctr[k][ui] - 2'd1;
          if (k == 1) m_ghr[k] = {m_ghr[k][2:0], ut};
          if (um && m_mp[k] < m_max[k]) m_mp[k]++;
        end
      end
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("bi_pred_valid", 32'(bi_pv), 32'(e.v));
    chk("bi_pred_taken", 32'(bi_pt), 32'(e.t));
    chk("bi_pred_index", 32'(bi_pi), 32'(e.i));
    chk("bi_ghr", 32'(bi_ghr), 32'(0));
    chk("bi_lookup_count", 32'(bi_lk), 32'(m_lk[0]));
    chk("bi_mispred_count", 32'(bi_mp), 32'(m_mp[0]));
    e = sbq.pop_front();
    chk("gs_pred_valid", 32'(gs_pv), 32'(e.v));
    chk("gs_pred_taken", 32'(gs_pt), 32'(e.t));
    chk("gs_pred_index", 32'(gs_pi), 32'(e.i));
    chk("gs_ghr", 32'(gs_ghr), 32'(m_ghr[1]));
    chk("gs_lookup_count", 32'(gs_lk), 32'(m_lk[1]));
    chk("gs_mispred_count", 32'(gs_mp), 32'(m_mp[1]));
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rst();
    cycle(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // reset state
    rst();
    chk("rst_pred_valid", 32'(bi_pv), 32'(0));
    chk("rst_gs_count", 32'(gs_lk), 32'(0));

    // bimodal first lookup returns weak not-taken
    cycle(0, 1, 32'h10, 0, 0, 0, 0);
    chk("t1_valid", 32'(bi_pv), 32'(1));
    chk("t1_taken", 32'(bi_pt), 32'(0));
    chk("t1_index", 32'(bi_pi), 32'(4));

    // saturate up, then back down
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 4, 1, 0);
    cycle(0, 1, 32'h10, 0, 0, 0, 0);
    chk("t2_sat_up", 32'(bi_pt), 32'(1));
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 4, 1, 0);
    cycle(0, 0, 0, 1, 4, 0, 0);
    cycle(0, 1, 32'h10, 0, 0, 0, 0);
    chk("t2_at_10", 32'(bi_pt), 32'(1));
    cycle(0, 0, 0, 1, 4, 0, 0);
    cycle(0, 1, 32'h10, 0, 0, 0, 0);
    chk("t2_at_01", 32'(bi_pt), 32'(0));
    idle();
    chk("t2_hold_taken", 32'(bi_pt), 32'(0));
    chk("t2_hold_index", 32'(bi_pi), 32'(4));

    // history T,T,N,T
    rst();
    cycle(0, 0, 0, 1, 9, 1, 0);
    cycle(0, 0, 0, 1, 9, 1, 0);
    cycle(0, 0, 0, 1, 9, 0, 0);
    cycle(0, 0, 0, 1, 9, 1, 0);
    chk("t3_ghr", 32'(gs_ghr), 32'hd);
    cycle(0, 1, 32'h0, 0, 0, 0, 0);
    chk("t3_idx_pc0", 32'(gs_pi), 32'hd);
    cycle(0, 1, 32'h34, 0, 0, 0, 0);
    chk("t3_idx_pc34", 32'(gs_pi), 32'h0);

    // same-cycle lookup/update, no bypass
    rst();
    cycle(0, 1, 32'h10, 1, 4, 1, 0);
    chk("t4_old_value", 32'(bi_pt), 32'(0));
    chk("t4_gs_index", 32'(gs_pi), 32'(4));
    cycle(0, 1, 32'h10, 0, 0, 0, 0);
    chk("t4_new_value", 32'(bi_pt), 32'(1));

    // statistics saturation; stray mispredict ignored
    rst();
    for (int i = 0; i < 20; i++)
      cycle(0, 1, 32'(i * 4), (i < 17), 4'(i),
            1'(i & 1), 1);
    chk("t5_lookups", 32'(gs_lk), 32'd15);
    chk("t5_mispreds", 32'(gs_mp), 32'd15);
    chk("t5_bi_mispreds", 32'(bi_mp), 32'd17);

    // reset wins over a concurrent update
    for (int i = 0; i < 6; i++)
      cycle(0, 0, 0, 1, 4'(i), 1, 1);
    cycle(1, 1, 32'h10, 1, 3, 1, 1);
    chk("t6_ghr", 32'(gs_ghr), 32'(0));
    chk("t6_valid", 32'(gs_pv), 32'(0));
    chk("t6_stats", 32'(gs_mp), 32'(0));
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, 32'(i * 4), 1, 4'(i), 1, 0);
      chk("t6_init_msb", 32'(bi_pt), 32'(0));
    end
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, 32'(i * 4), 0, 0, 0, 0);
      chk("t6_init_01", 32'(bi_pt), 32'(1));
    end

    // random traffic against the model
    rst();
    for (int n = 0; n < 300; n++)
      cycle(($urandom_range(0, 60) == 0),
            1'($urandom), $urandom,
            1'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
